tiger_dmem_router: RTL and testbench

Parametrised data-memory bypass router for the Tiger core. It replaces the single memory-mapped bypass master with up to 2**SEL_W Avalon-MM masters. Each core bypass access goes to the master selected by address bits. The router generates byte enables and replicated write data, and stalls the core until the access completes. A per-transaction timeout aborts hung accesses and reports them through sticky error status. It sits between the core's memread/memwrite outputs and the system interconnect, in parallel with the data-cache path.

---
 rtl/tiger_dmem_router_if.sv | 50 +++++
 rtl/tiger_dmem_router.sv | 176 +++++++++++++++++
 tb/tb_tiger_dmem_router.sv | 271 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/tiger_dmem_router_if.sv
// Bus bundle for tiger_dmem_router.
// Carries the core-side bypass request (mem_*), the per-port Avalon-MM
// master buses (avm_*, port p occupies slice p of each packed vector) and
// the sticky timeout status (err_*, busy).
//   slave  : the router's view (takes core requests, drives the avm masters)
//   master : the environment's view (core plus the Avalon slaves)
interface tiger_dmem_router_if #(
  parameter int SEL_W = 1
);
  localparam int NUM_PORTS = 2 ** SEL_W;

  logic                      mem_read;
  logic                      mem_write;
  logic                      mem8;
  logic                      mem16;
  logic [31:0]               mem_address;
  logic [31:0]               mem_writedata;
  logic [31:0]               mem_readdata;
  logic                      mem_stall;

  logic [32*NUM_PORTS-1:0]   avm_address;
  logic [NUM_PORTS-1:0]      avm_read;
  logic [NUM_PORTS-1:0]      avm_write;
  logic [32*NUM_PORTS-1:0]   avm_writedata;
  logic [4*NUM_PORTS-1:0]    avm_byteenable;
  logic [32*NUM_PORTS-1:0]   avm_readdata;
  logic [NUM_PORTS-1:0]      avm_waitrequest;
  logic [NUM_PORTS-1:0]      avm_readdatavalid;

  logic                      err_clear;
  logic                      err_timeout;
  logic [SEL_W-1:0]          err_port;
  logic                      busy;

  modport slave (
    input  mem_read, mem_write, mem8, mem16, mem_address, mem_writedata,
    input  avm_readdata, avm_waitrequest, avm_readdatavalid, err_clear,
    output mem_readdata, mem_stall,
    output avm_address, avm_read, avm_write, avm_writedata, avm_byteenable,
    output err_timeout, err_port, busy
  );

  modport master (
    output mem_read, mem_write, mem8, mem16, mem_address, mem_writedata,
    output avm_readdata, avm_waitrequest, avm_readdatavalid, err_clear,
    input  mem_readdata, mem_stall,
    input  avm_address, avm_read, avm_write, avm_writedata, avm_byteenable,
    input  err_timeout, err_port, busy
  );
endinterface

// File: rtl/tiger_dmem_router.sv
// Tiger data-memory bypass router.
// Steers each core bypass access to one of 2**SEL_W Avalon-MM masters chosen
// by mem_address[SEL_LSB +: SEL_W], builds byte enables and lane-replicated
// write data, and stalls the core until the access completes. A hung access
// is aborted after TIMEOUT_CYCLES cycles and flagged in sticky error status.
// Ports: clk, reset (synchronous, active-high), bus (tiger_dmem_router_if.slave).
//
// state   | meaning
// IDLE    | waiting for mem_read/mem_write
// REQ     | strobe on selected port until waitrequest drops
// WAIT_RD | read accepted, waiting for readdatavalid
// DONE    | one unstalled cycle so the core advances
module tiger_dmem_router #(
  parameter int          SEL_W          = 1,
  parameter int          SEL_LSB        = 29,
  parameter int          TIMEOUT_W      = 16,
  parameter int          TIMEOUT_CYCLES = 4096,
  parameter logic [31:0] ABORT_DATA     = 32'hDEADBEEF
) (
  input logic               clk,
  input logic               reset,
  tiger_dmem_router_if.slave bus
);
  localparam int NUM_PORTS = 2 ** SEL_W;

  typedef enum logic [1:0] {IDLE, REQ, WAIT_RD, DONE} state_t;

  state_t               state, state_nx;
  logic                 is_wr_q, is_b_q, is_h_q;
  logic [31:0]          addr_q, wd_q, rdata_q;
  logic [SEL_W-1:0]     port_q;
  logic [TIMEOUT_W-1:0] tmo_cnt;
  logic                 err_t_q;
  logic [SEL_W-1:0]     err_p_q;

  logic        req, active, timeout_hit;
  logic        strobe, capture, abort;
  logic        sel_wait, sel_rdv;
  logic [31:0] sel_rdata, wd_rep;
  logic [3:0]  be;

  assign req    = bus.mem_read | bus.mem_write;
  assign active = (state == REQ) || (state == WAIT_RD);
  assign timeout_hit = (TIMEOUT_CYCLES != 0) && active &&
                       (tmo_cnt == TIMEOUT_W'(TIMEOUT_CYCLES));

  always_comb begin
    sel_wait  = 1'b1;
    sel_rdv   = 1'b0;
    sel_rdata = '0;
    for (int p = 0; p < NUM_PORTS; p++) begin
      if (port_q == SEL_W'(p)) begin
        sel_wait  = bus.avm_waitrequest[p];
        sel_rdv   = bus.avm_readdatavalid[p];
        sel_rdata = bus.avm_readdata[32*p +: 32];
      end
    end
  end

  always_comb begin
    be     = 4'b1111;
    wd_rep = wd_q;
    if (is_b_q) begin
      be     = 4'b0001 << addr_q[1:0];
      wd_rep = {4{wd_q[7:0]}};
    end else if (is_h_q) begin
      be     = addr_q[1] ? 4'b1100 : 4'b0011;
      wd_rep = {2{wd_q[15:0]}};
    end
  end

  // Strobes are already low in the timeout cycle, so a REQ-state timeout
  // can never race an accept; in WAIT_RD a same-cycle readdatavalid wins.
  always_comb begin
    state_nx = state;
    strobe   = 1'b0;
    capture  = 1'b0;
    abort    = 1'b0;
    case (state)
      IDLE: if (req) state_nx = REQ;
      REQ: begin
        if (timeout_hit) begin
          abort    = 1'b1;
          state_nx = DONE;
        end else begin
          strobe = 1'b1;
          if (!sel_wait) begin
            if (is_wr_q) begin
              state_nx = DONE;
            end else if (sel_rdv) begin
              capture  = 1'b1;
              state_nx = DONE;
            end else begin
              state_nx = WAIT_RD;
            end
          end
        end
      end
      WAIT_RD: begin
        if (sel_rdv) begin
          capture  = 1'b1;
          state_nx = DONE;
        end else if (timeout_hit) begin
          abort    = 1'b1;
          state_nx = DONE;
        end
      end
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    bus.avm_address    = '0;
    bus.avm_read       = '0;
    bus.avm_write      = '0;
    bus.avm_writedata  = '0;
    bus.avm_byteenable = '0;
    for (int p = 0; p < NUM_PORTS; p++) begin
      if (strobe && (port_q == SEL_W'(p))) begin
        bus.avm_address[32*p +: 32]   = {addr_q[31:2], 2'b00};
        bus.avm_read[p]               = ~is_wr_q;
        bus.avm_write[p]              = is_wr_q;
        bus.avm_writedata[32*p +: 32] = wd_rep;
        bus.avm_byteenable[4*p +: 4]  = be;
      end
    end
  end

  assign bus.mem_stall    = ((state == IDLE) && req) || active;
  assign bus.busy         = (state != IDLE);
  assign bus.mem_readdata = rdata_q;
  assign bus.err_timeout  = err_t_q;
  assign bus.err_port     = err_p_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      is_wr_q <= 1'b0;
      is_b_q  <= 1'b0;
      is_h_q  <= 1'b0;
      addr_q  <= '0;
      wd_q    <= '0;
      port_q  <= '0;
      tmo_cnt <= '0;
      rdata_q <= '0;
      err_t_q <= 1'b0;
      err_p_q <= '0;
    end else begin
      state <= state_nx;
      if ((state == IDLE) && req) begin
        is_wr_q <= bus.mem_write;
        is_b_q  <= bus.mem8;
        is_h_q  <= bus.mem16 & ~bus.mem8;
        addr_q  <= bus.mem_address;
        wd_q    <= bus.mem_writedata;
        port_q  <= bus.mem_address[SEL_LSB +: SEL_W];
        tmo_cnt <= '0;
      end else if (active && (tmo_cnt != '1)) begin
        tmo_cnt <= tmo_cnt + TIMEOUT_W'(1);
      end
      if (capture) begin
        rdata_q <= sel_rdata;
      end else if (abort && !is_wr_q) begin
        rdata_q <= ABORT_DATA;
      end
      if (abort) begin
        err_t_q <= 1'b1;
        if (!err_t_q) err_p_q <= port_q;
      end else if (bus.err_clear) begin
        err_t_q <= 1'b0;
        err_p_q <= '0;
      end
    end
  end
endmodule

// File: tb/tb_tiger_dmem_router.sv
// Self-checking bench for tiger_dmem_router (SEL_W=1, TIMEOUT_CYCLES=8).
// A driver issues directed then random accesses and plays the Avalon slaves;
// for each access it pushes the expected outcome computed from the access
// rules into a queue. A monitor checks bus activity each cycle and pops the
// expectation whenever the router presents DONE.
module tb_tiger_dmem_router;
  localparam int          SEL_W = 1;
  localparam int          NP    = 2;
  localparam int          TMO   = 8;
  localparam logic [31:0] ABORT = 32'hDEADBEEF;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  tiger_dmem_router_if #(.SEL_W(SEL_W)) bus ();

  tiger_dmem_router #(
    .SEL_W(SEL_W), .SEL_LSB(29), .TIMEOUT_W(16),
    .TIMEOUT_CYCLES(TMO), .ABORT_DATA(ABORT)
  ) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );

  typedef struct {
    bit          wr;
    int          port;
    logic [31:0] addr;
    logic [31:0] be;
    logic [31:0] wd;
    logic [31:0] rdata;
    bit          err_t;
    int          err_p;
    int          stall;
    int          strobes;
  } exp_t;

  exp_t        sb[$];
  int          errors = 0;
  int          checks = 0;
  bit          mon_en = 1'b0;
  int          stall_cnt = 0;
  int          strobe_cnt = 0;
  logic [31:0] m_rd = '0;
  bit          m_err = 1'b0;
  int          m_errp = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, req, $time);
    end
  endtask

  // Monitor
  initial begin : monitor
    int   sp;
    int   nstb;
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (mon_en) begin
        sp   = -1;
        nstb = 0;
        for (int p = 0; p < NP; p++)
          if (bus.avm_read[p] || bus.avm_write[p]) begin
            sp = p;
            nstb++;
          end
        if (bus.mem_stall) stall_cnt++;
        if (nstb > 0) strobe_cnt++;
        if (nstb > 1) chk("one_port_strobed", 32'(nstb), 32'd1);
        for (int p = 0; p < NP; p++)
          if (p != sp)
            chk("unselected_port_zero",
                bus.avm_address[32*p +: 32] | bus.avm_writedata[32*p +: 32] |
                {28'd0, bus.avm_byteenable[4*p +: 4]} |
                {30'd0, bus.avm_read[p], bus.avm_write[p]}, 32'd0);
        if (sp >= 0) begin
          if (sb.size() == 0) begin
            chk("spurious_strobe", 32'd1, 32'd0);
          end else begin
            e = sb[0];
            chk("strobe_port", 32'(sp), 32'(e.port));
            chk("strobe_is_write", 32'(bus.avm_write[sp]), 32'(e.wr));
            chk("avm_address", bus.avm_address[32*sp +: 32], e.addr);
            chk("avm_byteenable", 32'(bus.avm_byteenable[4*sp +: 4]), e.be);
            if (e.wr) chk("avm_writedata", bus.avm_writedata[32*sp +: 32], e.wd);
          end
        end
        if (bus.busy && !bus.mem_stall) begin
          if (sb.size() == 0) begin
            chk("spurious_done", 32'd1, 32'd0);
          end else begin
            e = sb.pop_front();
            chk("mem_readdata", bus.mem_readdata, e.rdata);
            chk("err_timeout", 32'(bus.err_timeout), 32'(e.err_t));
            chk("err_port", 32'(bus.err_port), 32'(e.err_p));
            chk("stall_cycles", 32'(stall_cnt), 32'(e.stall));
            chk("strobe_cycles", 32'(strobe_cnt), 32'(e.strobes));
          end
          stall_cnt  = 0;
          strobe_cnt = 0;
        end
      end
    end
  end

  // W: cycles of waitrequest before accept; D: cycles from accept to
  // readdatavalid (0 = same cycle). Relative cycle 0 is the first REQ cycle;
  // the abort happens in relative cycle TMO with strobes already low.
  task automatic run_txn(input bit rd, input bit wr, input bit m8, input bit m16,
                         input logic [31:0] addr, input logic [31:0] wd,
                         input int w, input int d, input bit clr,
                         input logic [31:0] rdat);
    exp_t e;
    int   p, e_end, n;
    bit   tmo, done;
    p      = int'(addr[29]);
    e.wr   = wr;
    e.port = p;
    e.addr = addr & 32'hFFFF_FFFC;
    if (m8) begin
      e.be = 32'd1 << (addr % 4);
      e.wd = (wd & 32'hFF) * 32'h0101_0101;
    end else if (m16) begin
      e.be = ((addr / 2) % 2 == 1) ? 32'hC : 32'h3;
      e.wd = (wd & 32'hFFFF) * 32'h0001_0001;
    end else begin
      e.be = 32'hF;
      e.wd = wd;
    end
    if (wr) begin
      tmo       = (w >= TMO);
      e_end     = tmo ? TMO : w;
      e.strobes = tmo ? TMO : w + 1;
    end else if (w >= TMO) begin
      tmo = 1; e_end = TMO; e.strobes = TMO;
    end else if (w + d <= TMO) begin
      tmo = 0; e_end = w + d; e.strobes = w + 1;
    end else begin
      tmo = 1; e_end = TMO; e.strobes = w + 1;
    end
    e.stall = e_end + 2;
    if (clr) begin m_err = 0; m_errp = 0; end
    if (tmo) begin
      if (!m_err) m_errp = p;
      m_err = 1;
    end
    if (!wr) m_rd = tmo ? ABORT : rdat;
    e.rdata = m_rd;
    e.err_t = m_err;
    e.err_p = m_errp;
    sb.push_back(e);

    @(negedge clk);
    bus.mem_read = rd; bus.mem_write = wr; bus.mem8 = m8; bus.mem16 = m16;
    bus.mem_address = addr; bus.mem_writedata = wd; bus.err_clear = clr;
    bus.avm_waitrequest = '1; bus.avm_readdatavalid = '0;
    n = 0; done = 0;
    while (!done) begin
      @(negedge clk);
      if (!bus.mem_stall) begin
        done = 1;
      end else begin
        if (n > 40) begin
          errors++;
          $display("FAIL txn_hang: no completion after %0d cycles, expected %0d", n, e_end);
          $display("Result: errors=%0d of %0d checks", errors, checks);
          $fatal(1, "hung transaction");
        end
        for (int k = 0; k < NP; k++) begin
          bus.avm_waitrequest[k]      = 1'b1;
          bus.avm_readdatavalid[k]    = (k != p) ? 1'($urandom_range(0, 1)) : 1'b0;
          bus.avm_readdata[32*k +: 32] = $urandom();
        end
        bus.avm_waitrequest[p] = (n < w);
        if (!wr && (n == w + d)) begin
          bus.avm_readdatavalid[p]     = 1'b1;
          bus.avm_readdata[32*p +: 32] = rdat;
        end
        n++;
      end
    end
    bus.mem_read = 0; bus.mem_write = 0; bus.err_clear = 0;
    bus.avm_readdatavalid = '0; bus.avm_waitrequest = '1;
    if (!wr && tmo) begin
      @(negedge clk);
      bus.avm_readdatavalid[p]     = 1'b1;
      bus.avm_readdata[32*p +: 32] = ~rdat;
      @(negedge clk);
      bus.avm_readdatavalid = '0;
    end
  endtask

  task automatic clear_err();
    @(negedge clk);
    bus.err_clear = 1;
    m_err = 0; m_errp = 0;
    @(negedge clk);
    bus.err_clear = 0;
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_avm_strobes"}, {28'd0, bus.avm_read, bus.avm_write}, 32'd0);
    chk({tag, "_avm_address"}, bus.avm_address[31:0] | bus.avm_address[63:32], 32'd0);
    chk({tag, "_avm_wd_be"}, bus.avm_writedata[31:0] | bus.avm_writedata[63:32] |
        {24'd0, bus.avm_byteenable}, 32'd0);
    chk({tag, "_mem_readdata"}, bus.mem_readdata, 32'd0);
    chk({tag, "_err"}, {30'd0, bus.err_timeout, bus.err_port}, 32'd0);
    chk({tag, "_busy_stall"}, {30'd0, bus.busy, bus.mem_stall}, 32'd0);
  endtask

  initial begin : driver
    bit rd, wr;
    bus.mem_read = 0; bus.mem_write = 0; bus.mem8 = 0; bus.mem16 = 0;
    bus.mem_address = '0; bus.mem_writedata = '0; bus.err_clear = 0;
    bus.avm_readdata = '0; bus.avm_waitrequest = '1; bus.avm_readdatavalid = '0;
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    reset = 0;
    mon_en = 1;

    run_txn(0, 1, 0, 0, 32'h2000_0010, 32'hCAFE_F00D, 0, 0, 0, 0);
    run_txn(0, 1, 1, 0, 32'h0000_0003, 32'h0000_00A5, 0, 0, 0, 0);
    run_txn(0, 1, 0, 1, 32'h0000_0002, 32'h1234_BEEF, 1, 0, 0, 0);
    run_txn(1, 0, 0, 0, 32'h2000_0100, 0, 3, 2, 0, 32'h1234_5678);
    run_txn(1, 0, 0, 0, 32'h2000_0200, 0, 0, 30, 0, 32'h5555_0000);
    run_txn(1, 0, 0, 0, 32'h0000_0044, 0, 20, 0, 0, 32'h6666_0000);
    clear_err();
    run_txn(1, 1, 1, 1, 32'h0000_0011, 32'h0000_3C5A, 0, 0, 0, 32'h7777_0000);
    run_txn(1, 0, 0, 0, 32'h2000_0008, 0, 2, 6, 0, 32'hA1B2_C3D4);
    run_txn(0, 1, 0, 0, 32'h2000_0020, 32'h0F0F_0F0F, 8, 0, 1, 0);

    // reset while waiting for readdatavalid
    mon_en = 0;
    @(negedge clk);
    bus.mem_read = 1; bus.mem_address = 32'h2000_0040;
    bus.avm_waitrequest = '0;
    @(negedge clk);
    @(negedge clk);
    chk("pre_reset_busy", 32'(bus.busy), 32'd1);
    reset = 1; bus.mem_read = 0;
    @(negedge clk);
    check_all_zero("mid_reset");
    reset = 0;
    bus.avm_waitrequest = '1;
    m_rd = '0; m_err = 0; m_errp = 0;
    sb.delete();
    stall_cnt = 0; strobe_cnt = 0;
    mon_en = 1;
    run_txn(1, 0, 0, 0, 32'h2000_0040, 0, 1, 1, 0, 32'h0BAD_F00D);

    for (int i = 0; i < 120; i++) begin
      rd = 1'($urandom_range(0, 1));
      wr = !rd || ($urandom_range(0, 3) == 0);
      run_txn(rd, wr, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
              $urandom(), $urandom(), $urandom_range(0, 10), $urandom_range(0, 10),
              ($urandom_range(0, 7) == 0), $urandom());
      if ($urandom_range(0, 9) == 0) clear_err();
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    repeat (3) @(negedge clk);
    chk("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
